vehicle_sensor_conditioner: RTL and testbench
=============================================

Name: vehicle_sensor_conditioner

Overview:
Upstream stage of the highway/country traffic signal controller. Conditions the raw country-road vehicle detector by synchronising, debouncing and detecting arrivals. Keeps a saturating queue count of waiting cars and drains it while the controller shows country GREEN. Drives the controller's X (car-present) input; the controller's cntry light output is fed back so the block knows when cars are being served.

Parameters:
DEBOUNCE, 4, consecutive synchronised samples required before the filtered sensor level changes (>=1)
DEPART_CYCLES, 8, clock cycles per departing car while country is GREEN (>=1)
MAX_CARS, 15, saturation value of the queue counter
CW, 4, width of car_count; must satisfy 2**CW > MAX_CARS
GREEN_CODE, 2'd2, cntry encoding for GREEN (RED=0, YELLOW=1, GREEN=2)

Ports:
clock  input  1  single system clock, rising edge
clear  input  1  synchronous active-high reset
sensor_raw  input  1  asynchronous, bouncy vehicle loop detector, 1 = vehicle over loop
cntry  input  2  country-road light state from the signal controller
X  output  1  registered car-waiting flag to the controller
car_count  output  CW  registered number of waiting cars
overflow  output  1  sticky flag: an arrival occurred while car_count == MAX_CARS

Behaviour:
- Interface: one clock (clock). Reset is clear: synchronous, active-high. All state updates on the rising edge of clock.
- Reset (clear=1 at an edge): sync flops=0, filtered=0, debounce counter=0, depart timer=0, state=IDLE, X=0, car_count=0, overflow=0. Reset overrides every other event in the same cycle. A mid-operation reset discards queued cars.
- Synchroniser: two-flop chain on sensor_raw, output sync.
- Debounce: the counter increments each cycle sync != filtered and clears when they are equal. Once DEBOUNCE consecutive differing samples are seen, filtered toggles and the counter clears. Any pulse shorter than DEBOUNCE sync cycles is ignored.
- Arrival = filtered rising edge (single-cycle pulse). A falling edge has no effect.
- Departure: while cntry == GREEN_CODE, the depart timer counts 0..DEPART_CYCLES-1.
  - At DEPART_CYCLES-1 a departure pulse is generated and the timer wraps to 0.
  - When cntry != GREEN_CODE the timer holds at 0.
  - The first departure occurs DEPART_CYCLES cycles after GREEN is first sampled.
  - A departure with car_count == 0 is ignored.
- Count update, same edge:
  - Arrival only: +1, saturating at MAX_CARS. An arrival at MAX_CARS sets overflow.
  - Departure only: -1 if car_count > 0.
  - Arrival and departure together: car_count unchanged, overflow not set.
- FSM (state register, next state from next car_count):
  - IDLE: next count == 0. X=0.
  - REQ: next count > 0 and cntry != GREEN. X=1.
  - SERVE: next count > 0 and cntry == GREEN. X=1.
  - Transitions: IDLE->REQ on arrival; REQ->SERVE when GREEN sampled; SERVE->REQ when GREEN drops with cars left; SERVE->IDLE when count reaches 0; REQ->IDLE never without a departure.
- X is registered and equals (next car_count != 0). It changes on the same edge as car_count.
- Latency: sensor_raw stable high before edge n gives sync=1 after edge n+1, filtered=1 after edge n+1+DEBOUNCE, and car_count/X updated at edge n+2+DEBOUNCE (edge n+6 with defaults).
- overflow is sticky until clear.

Test Plan:
1. Reset: clear=1 for 2 cycles with sensor_raw toggling -> X=0, car_count=0, overflow=0 throughout and after release.
2. Glitch rejection: sensor_raw high for 3 cycles then low (DEBOUNCE=4) -> car_count stays 0, X stays 0.
3. Single car: sensor_raw high 10 cycles from before edge 0, cntry=RED -> car_count=1 and X=1 after edge 6. Then cntry=GREEN from edge 20 -> car_count=0 and X=0 after edge 28.
4. Saturation: 17 clean arrivals (high 6 / low 6 cycles each), cntry=RED -> car_count=15, overflow=1 after the 16th arrival, unchanged after the 17th.
5. Simultaneous: car_count=3, cntry=GREEN, arrival pulse timed to coincide with a departure edge -> car_count stays 3 at that edge.
6. Partial serve and mid-run reset: car_count=2, GREEN for 9 cycles then YELLOW -> car_count=1, X=1, timer frozen. Then clear=1 for one cycle -> car_count=0, X=0, overflow=0 at that edge.

Source files
------------

// File: rtl/vehicle_sensor_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vehicle_sensor_conditioner                                                 |
// | Country-road detector conditioning: sync, debounce, arrival/departure      |
// | counting and car-waiting request (X) for the traffic signal controller.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vehicle_sensor_conditioner #(
  parameter int         DEBOUNCE      = 4,
  parameter int         DEPART_CYCLES = 8,
  parameter int         MAX_CARS      = 15,
  parameter int         CW            = 4,
  parameter logic [1:0] GREEN_CODE    = 2'd2
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          sensor_raw,
  input  logic [1:0]    cntry,
  output logic          X,
  output logic [CW-1:0] car_count,
  output logic          overflow
);

  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TW  = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

  localparam logic [DBW-1:0] C_DEB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [TW-1:0]  C_TMR_LAST = TW'(DEPART_CYCLES - 1);
  localparam logic [CW-1:0]  C_MAX_CARS = CW'(MAX_CARS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  logic           sync1_q, sync1_d;
  logic           sync_q, sync_d;
  logic           filtered_q, filtered_d;
  logic           filt_prev_q, filt_prev_d;
  logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           depart_q, depart_d;
  logic [CW-1:0]  car_count_q, car_count_d;
  logic           overflow_q, overflow_d;
  logic           x_q, x_d;
  state_t         state_q, state_d;

  logic           arrival;
  logic           departure;
  logic           is_green;

  always_comb begin
    sync1_d     = sensor_raw;
    sync_d      = sync1_q;
    filtered_d  = filtered_q;
    deb_cnt_d   = '0;
    filt_prev_d = filtered_q;

    // Counter only advances while the synchronised level disagrees with the filter.
    if (sync_q != filtered_q) begin
      if (deb_cnt_q == C_DEB_LAST) begin
        filtered_d = ~filtered_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    arrival  = filtered_q & ~filt_prev_q;
    is_green = (cntry == GREEN_CODE);

    // Departure pulse is registered so the first one lands DEPART_CYCLES after GREEN.
    timer_d  = '0;
    depart_d = 1'b0;
    if (is_green) begin
      if (timer_q == C_TMR_LAST) begin
        depart_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    departure = depart_q && (car_count_q != '0);

    car_count_d = car_count_q;
    overflow_d  = overflow_q;
    case ({arrival, departure})
      2'b10: begin
        if (car_count_q == C_MAX_CARS) begin
          overflow_d = 1'b1;
        end else begin
          car_count_d = car_count_q + 1'b1;
        end
      end
      2'b01:   car_count_d = car_count_q - 1'b1;
      default: car_count_d = car_count_q;
    endcase

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (car_count_d != '0) begin
          state_d = is_green ? ST_SERVE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (car_count_d == '0) begin
          state_d = ST_IDLE;
        end else if (is_green) begin
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (car_count_d == '0) begin
          state_d = ST_IDLE;
        end else if (!is_green) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    x_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      sync1_q     <= 1'b0;
      sync_q      <= 1'b0;
      filtered_q  <= 1'b0;
      filt_prev_q <= 1'b0;
      deb_cnt_q   <= '0;
      timer_q     <= '0;
      depart_q    <= 1'b0;
      car_count_q <= '0;
      overflow_q  <= 1'b0;
      x_q         <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      sync1_q     <= sync1_d;
      sync_q      <= sync_d;
      filtered_q  <= filtered_d;
      filt_prev_q <= filt_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      timer_q     <= timer_d;
      depart_q    <= depart_d;
      car_count_q <= car_count_d;
      overflow_q  <= overflow_d;
      x_q         <= x_d;
      state_q     <= state_d;
    end
  end

  assign X         = x_q;
  assign car_count = car_count_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vehicle_sensor_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vehicle_sensor_conditioner                                              |
// | Directed bench with an edge-indexed scoreboard of expected outputs.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vehicle_sensor_conditioner;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  logic       clock;
  logic       clear;
  logic       sensor_raw;
  logic [1:0] cntry;
  logic       X;
  logic [3:0] car_count;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  typedef struct {
    string      tag;
    int         e;
    logic [3:0] cnt;
    logic       x;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  vehicle_sensor_conditioner #(
    .DEBOUNCE(4), .DEPART_CYCLES(8), .MAX_CARS(15), .CW(4), .GREEN_CODE(2'd2)
  ) dut (
    .clock(clock),
    .clear(clear),
    .sensor_raw(sensor_raw),
    .cntry(cntry),
    .X(X),
    .car_count(car_count),
    .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) edge_n <= edge_n + 1;

  // Outputs are compared at the falling edge that follows the target rising edge.
  always @(negedge clock) begin
    while (sb.size() != 0 && sb[0].e <= edge_n) begin
      exp_t t;
      t = sb.pop_front();
      tests++;
      assert (t.e == edge_n) else begin
        fails++;
        $error("FAIL %s check edge observed %0d expected %0d", t.tag, edge_n, t.e);
      end
      tests++;
      assert (car_count === t.cnt) else begin
        fails++;
        $error("FAIL %s car_count observed %0d expected %0d", t.tag, car_count, t.cnt);
      end
      tests++;
      assert (X === t.x) else begin
        fails++;
        $error("FAIL %s X observed %b expected %b", t.tag, X, t.x);
      end
      tests++;
      assert (overflow === t.ovf) else begin
        fails++;
        $error("FAIL %s overflow observed %b expected %b", t.tag, overflow, t.ovf);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_at(input string tag, input int e, input int cnt,
                           input logic x, input logic ovf);
    exp_t t;
    t.tag = tag;
    t.e   = e;
    t.cnt = 4'(cnt);
    t.x   = x;
    t.ovf = ovf;
    sb.push_back(t);
  endtask

  initial begin
    int b;
    int n0;
    int c;

    // Reset held two edges while the sensor toggles.
    clear = 1'b1; sensor_raw = 1'b0; cntry = RED;
    expect_at("rst_e1", 1, 0, 1'b0, 1'b0);
    expect_at("rst_e2", 2, 0, 1'b0, 1'b0);
    step(1); sensor_raw = 1'b1;
    step(1); sensor_raw = 1'b0; clear = 1'b0;
    expect_at("rst_rel", 3, 0, 1'b0, 1'b0);
    expect_at("rst_idle", 8, 0, 1'b0, 1'b0);
    step(8);

    // A 3-cycle pulse is shorter than the debounce window.
    b = edge_n;
    sensor_raw = 1'b1;
    step(3); sensor_raw = 1'b0;
    expect_at("glitch_a", b + 6, 0, 1'b0, 1'b0);
    expect_at("glitch_b", b + 12, 0, 1'b0, 1'b0);
    step(14);

    // Single car: arrival latency, GREEN drain, departure with empty queue.
    n0 = edge_n + 1;
    sensor_raw = 1'b1;
    expect_at("car_lat_pre", n0 + 5, 0, 1'b0, 1'b0);
    expect_at("car_arrive", n0 + 6, 1, 1'b1, 1'b0);
    expect_at("car_pre_dep", n0 + 27, 1, 1'b1, 1'b0);
    expect_at("car_depart", n0 + 28, 0, 1'b0, 1'b0);
    expect_at("empty_dep", n0 + 36, 0, 1'b0, 1'b0);
    expect_at("empty_dep2", n0 + 38, 0, 1'b0, 1'b0);
    step(10); sensor_raw = 1'b0;
    step(10); cntry = GREEN;
    step(19); cntry = RED;
    step(4);

    // Saturation: 17 clean arrivals while RED.
    for (int k = 0; k < 17; k++) begin
      b = edge_n;
      sensor_raw = 1'b1;
      expect_at($sformatf("sat_%0d", k), b + 7, (k + 1 > 15) ? 15 : k + 1,
                1'b1, (k >= 15) ? 1'b1 : 1'b0);
      step(6); sensor_raw = 1'b0;
      step(6);
    end

    clear = 1'b1;
    expect_at("clr_sat", edge_n + 1, 0, 1'b0, 1'b0);
    step(1); clear = 1'b0;
    step(2);

    for (int k = 0; k < 3; k++) begin
      b = edge_n;
      sensor_raw = 1'b1;
      expect_at($sformatf("fill_%0d", k), b + 7, k + 1, 1'b1, 1'b0);
      step(6); sensor_raw = 1'b0;
      step(6);
    end

    // Arrival lands on the same edge as the first departure.
    b = edge_n;
    cntry = GREEN;
    expect_at("simul_pre", b + 8, 3, 1'b1, 1'b0);
    expect_at("simul_edge", b + 9, 3, 1'b1, 1'b0);
    expect_at("simul_next", b + 17, 2, 1'b1, 1'b0);
    step(2); sensor_raw = 1'b1;
    step(6); sensor_raw = 1'b0;
    step(9); cntry = RED;
    step(3);

    // Partial serve, timer frozen on YELLOW, then mid-run reset.
    c = edge_n;
    cntry = GREEN;
    expect_at("part_pre", c + 8, 2, 1'b1, 1'b0);
    expect_at("part_dep", c + 9, 1, 1'b1, 1'b0);
    expect_at("part_hold", c + 20, 1, 1'b1, 1'b0);
    expect_at("mid_clear", c + 21, 0, 1'b0, 1'b0);
    step(9); cntry = YELLOW;
    step(11); clear = 1'b1;
    step(1); clear = 1'b0;
    step(3);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain pending observed %0d expected %0d", sb.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
